// File: rtl/status_pkg.sv
// Shared types and widths for the status debounce front end.
// STATUS_DEBOUNCE_TIMESTAMP_EN adds a 16-bit timestamp to each event entry.
package status_pkg;

  localparam int unsigned STATUS_W = 9;
  localparam int unsigned DB_CNT_W = 8;

  typedef logic [STATUS_W-1:0] status_t;

  typedef struct packed {
    status_t     data;
    status_t     mask;
`ifdef STATUS_DEBOUNCE_TIMESTAMP_EN
    logic [15:0] tstamp;
`endif
  } status_evt_t;

endpackage

// File: rtl/status_evt_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO is dropped
// unless a pop happens in the same cycle.
module status_evt_fifo
  import status_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        push,
  input  status_evt_t push_data,
  input  logic        pop,
  output status_evt_t head,
  output logic        full,
  output logic        empty,
  output logic        drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  status_evt_t     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign head    = mem[rd_ptr];

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/status_debounce.sv
// Synchronises and debounces the raw status word and queues change events.
// STATUS_DEBOUNCE_TIMESTAMP_EN adds evt_time and a free-running cycle counter.
module status_debounce
  import status_pkg::*;
#(
  parameter int unsigned W        = STATUS_W,
  parameter int unsigned DB_COUNT = 4,
  parameter int unsigned DEPTH    = 4
) (
  input  logic         sysclk,
  input  logic         reset,
  input  logic [W-1:0] status_in,
  input  logic         sample_tick,
  input  logic         clear_ovf,
  output logic [W-1:0] stable_status,
  output logic         evt_valid,
  input  logic         evt_ready,
  output logic [W-1:0] evt_data,
  output logic [W-1:0] evt_mask,
`ifdef STATUS_DEBOUNCE_TIMESTAMP_EN
  output logic [15:0]  evt_time,
`endif
  output logic         overflow
);

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_COUNT - 1);

  logic [W-1:0]        sync1;
  logic [W-1:0]        sync2;
  logic [W-1:0]        stable;
  logic [W-1:0]        stable_next;
  logic [W-1:0]        flip;
  logic [DB_CNT_W-1:0] cnt      [W];
  logic [DB_CNT_W-1:0] cnt_next [W];

  status_evt_t push_entry;
  status_evt_t head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_drop;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= status_in;
      sync2 <= sync1;
    end
  end

  // A counter only advances while its bit disagrees with the stable value;
  // any agreeing cycle restarts it, so short glitches never accumulate.
  always_comb begin
    stable_next = stable;
    for (int unsigned i = 0; i < W; i++) begin
      cnt_next[i] = cnt[i];
      if (sync2[i] == stable[i]) begin
        cnt_next[i] = '0;
      end else if (sample_tick) begin
        if (cnt[i] == DB_LAST) begin
          stable_next[i] = sync2[i];
          cnt_next[i]    = '0;
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      stable <= '0;
      for (int unsigned i = 0; i < W; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable <= stable_next;
      for (int unsigned i = 0; i < W; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  assign flip = stable ^ stable_next;

`ifdef STATUS_DEBOUNCE_TIMESTAMP_EN
  logic [15:0] ts;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      ts <= '0;
    end else begin
      ts <= ts + 1'b1;
    end
  end

  always_comb begin
    push_entry        = '0;
    push_entry.data   = stable_next;
    push_entry.mask   = flip;
    push_entry.tstamp = ts;
  end

  assign evt_time = head.tstamp;
`else
  always_comb begin
    push_entry      = '0;
    push_entry.data = stable_next;
    push_entry.mask = flip;
  end
`endif

  status_evt_fifo #(
    .DEPTH (DEPTH)
  ) u_evt_fifo (
    .sysclk    (sysclk),
    .reset     (reset),
    .push      (|flip),
    .push_data (push_entry),
    .pop       (evt_ready),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

  logic unused_full;
  assign unused_full = fifo_full;

  assign stable_status = stable;
  assign evt_valid     = !fifo_empty;
  assign evt_data      = head.data;
  assign evt_mask      = head.mask;

endmodule

// File: tb/tb_status_debounce.sv
// Directed bench for status_debounce: debounce, glitch rejection, FIFO
// overflow, simultaneous push/pop at full, and mid-operation reset.
module tb_status_debounce;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b0;
  logic [8:0] status_in   = '0;
  logic       sample_tick = 1'b0;
  logic       clear_ovf   = 1'b0;
  logic       evt_ready   = 1'b0;
  logic [8:0] stable_status;
  logic       evt_valid;
  logic [8:0] evt_data;
  logic [8:0] evt_mask;
  logic       overflow;
`ifdef STATUS_DEBOUNCE_TIMESTAMP_EN
  logic [15:0] evt_time;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 sysclk = ~sysclk;

  status_debounce #(
    .W        (9),
    .DB_COUNT (4),
    .DEPTH    (4)
  ) dut (
    .sysclk        (sysclk),
    .reset         (reset),
    .status_in     (status_in),
    .sample_tick   (sample_tick),
    .clear_ovf     (clear_ovf),
    .stable_status (stable_status),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_data      (evt_data),
    .evt_mask      (evt_mask),
`ifdef STATUS_DEBOUNCE_TIMESTAMP_EN
    .evt_time      (evt_time),
`endif
    .overflow      (overflow)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  // Seven idle cycles, then one cycle with sample_tick high; evt_ready may
  // be raised in that same tick cycle.
  task automatic tick(input logic rdy);
    repeat (7) step();
    sample_tick = 1'b1;
    evt_ready   = rdy;
    step();
    sample_tick = 1'b0;
    evt_ready   = 1'b0;
  endtask

  task automatic apply(input logic [8:0] word, input logic last_rdy);
    status_in = word;
    repeat (3) tick(1'b0);
    tick(last_rdy);
  endtask

  task automatic pop_check(input string tag, input logic [8:0] d, input logic [8:0] m);
    check_eq({tag, "_valid"}, 16'(evt_valid), 16'h1);
    check_eq({tag, "_data"}, 16'(evt_data), 16'(d));
    check_eq({tag, "_mask"}, 16'(evt_mask), 16'(m));
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
  endtask

  logic [8:0] ov_data [4] = '{9'h0AA, 9'h1FF, 9'h000, 9'h0F0};
  logic [8:0] ov_mask [4] = '{9'h1FF, 9'h155, 9'h1FF, 9'h0F0};

  initial begin
    // Reset state
    repeat (3) step();
    check_eq("rst_stable", 16'(stable_status), 16'h000);
    check_eq("rst_valid", 16'(evt_valid), 16'h0);
    reset = 1'b1;
    step();
    check_eq("rel_stable", 16'(stable_status), 16'h000);
    check_eq("rel_valid", 16'(evt_valid), 16'h0);
    check_eq("rel_ovf", 16'(overflow), 16'h0);
    check_eq("rel_data", 16'(evt_data), 16'h000);
    check_eq("rel_mask", 16'(evt_mask), 16'h000);

    // Basic debounce: change accepted on the 4th tick only
    status_in = 9'h155;
    repeat (3) tick(1'b0);
    check_eq("db_3tick_stable", 16'(stable_status), 16'h000);
    check_eq("db_3tick_valid", 16'(evt_valid), 16'h0);
    tick(1'b0);
    check_eq("db_4tick_stable", 16'(stable_status), 16'h155);
    pop_check("db_evt", 9'h155, 9'h155);
    check_eq("db_drained", 16'(evt_valid), 16'h0);

    // Glitch of 3 ticks on bit0, twice: counter must restart between them
    for (int p = 0; p < 2; p++) begin
      status_in = 9'h154;
      repeat (3) tick(1'b0);
      status_in = 9'h155;
      repeat (4) step();
      check_eq("glitch_stable", 16'(stable_status), 16'h155);
      check_eq("glitch_valid", 16'(evt_valid), 16'h0);
    end
    tick(1'b0);
    check_eq("glitch_after", 16'(stable_status), 16'h155);

    // Overflow: 5 events into a 4-deep FIFO
    apply(9'h0AA, 1'b0);
    apply(9'h1FF, 1'b0);
    apply(9'h000, 1'b0);
    apply(9'h0F0, 1'b0);
    check_eq("ov_before", 16'(overflow), 16'h0);
    apply(9'h00F, 1'b0);
    check_eq("ov_set", 16'(overflow), 16'h1);
    check_eq("ov_stable", 16'(stable_status), 16'h00F);
    repeat (5) step();
    check_eq("ov_hold_data", 16'(evt_data), 16'h0AA);
    for (int i = 0; i < 4; i++) begin
      pop_check("ov_drain", ov_data[i], ov_mask[i]);
    end
    check_eq("ov_empty", 16'(evt_valid), 16'h0);
    check_eq("ov_sticky", 16'(overflow), 16'h1);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    check_eq("ov_cleared", 16'(overflow), 16'h0);

    // Full FIFO with a push coinciding with a pop
    apply(9'h100, 1'b0);
    apply(9'h010, 1'b0);
    apply(9'h001, 1'b0);
    apply(9'h1F0, 1'b0);
    apply(9'h0AA, 1'b1);
    check_eq("fp_ovf", 16'(overflow), 16'h0);
    pop_check("fp_e2", 9'h010, 9'h110);
    pop_check("fp_e3", 9'h001, 9'h011);
    pop_check("fp_e4", 9'h1F0, 9'h1F1);
    pop_check("fp_e5", 9'h0AA, 9'h15A);
    check_eq("fp_empty", 16'(evt_valid), 16'h0);

    // Reset while three events are queued
    apply(9'h155, 1'b0);
    apply(9'h000, 1'b0);
    apply(9'h1FF, 1'b0);
    check_eq("mr_queued", 16'(evt_valid), 16'h1);
    reset = 1'b0;
    #1;
    check_eq("mr_valid", 16'(evt_valid), 16'h0);
    check_eq("mr_stable", 16'(stable_status), 16'h000);
    check_eq("mr_data", 16'(evt_data), 16'h000);
    step();
    reset = 1'b1;
    step();
    check_eq("mr_rel_valid", 16'(evt_valid), 16'h0);
    repeat (4) tick(1'b0);
    check_eq("mr_stable_after", 16'(stable_status), 16'h1FF);
    pop_check("mr_evt", 9'h1FF, 9'h1FF);
    check_eq("mr_single", 16'(evt_valid), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
